// File: rtl/dma_bus_pkg.sv
// Shared bus definitions for the DMA master port and its bus responders.
// Contents:
//   bus_slv_state_t  responder FSM states
//   BEAT_W           beat counter width (holds 0..256)
//   WORD_W, BE_W     bus data width and byte-lane count
//   RD, WR           read_n_write encodings
package dma_bus_pkg;

    localparam int BEAT_W = 9;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        READ,
        ABORT
    } bus_slv_state_t;

endpackage

// File: rtl/dma_slave_sram.sv
// Single-port word SRAM with byte-lane write enables and a one-cycle
// synchronous read.
// Ports:
//   clk    clock
//   we     write strobe
//   be     byte-lane mask for the write
//   addr   word address (shared by read and write)
//   wdata  write data
//   rdata  data of the word addressed on the previous edge
module dma_slave_sram
    import dma_bus_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [BE_W-1:0]      be,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dma_bus_slave_mem.sv
// Bus responder backing a word-addressed SRAM window at BASE_ADDR on the
// DMA shared bus. Takes single or burst writes, answers burst reads,
// flags misaligned hits and write overruns, ignores addresses outside
// the window.
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   begin_transaction_in          start strobe, address on address_data_in
//   end_transaction_in            ends a write burst / aborts a read
//   read_n_write_in, burst_size_in, byte_enables_in   sampled with begin
//   data_valid_in, address_data_in                   write beats
//   address_data_out, data_valid_out                 read beats (0 when idle)
//   end_transaction_out           pulse closing a read burst or an address error
//   busy_out                      stall; master holds its current beat
//   error_out                     pulse on misaligned hit or write overrun
// Handshake: a write beat moves on a cycle with data_valid_in=1 and
// busy_out=0; a read beat moves on a cycle with data_valid_out=1.
// Build option: define BUSY_INJECT_EN to raise busy_out for one cycle after
// every BUSY_PERIOD beats; without it busy_out is constant 0.
module dma_bus_slave_mem
    import dma_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          BUSY_PERIOD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic        end_transaction_in,
    input  logic        read_n_write_in,
    input  logic [7:0]  burst_size_in,
    input  logic [3:0]  byte_enables_in,
    input  logic        data_valid_in,
    input  logic [31:0] address_data_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        busy_out,
    output logic        error_out
);

    if (BASE_ADDR[ADDR_BITS+1:0] != '0) begin : g_bad_base
        $error("BASE_ADDR is not aligned to the window size");
    end
    if (BUSY_PERIOD < 1) begin : g_bad_period
        $error("BUSY_PERIOD must be at least 1");
    end

    bus_slv_state_t state, state_next;

    logic [ADDR_BITS-1:0] ptr;        // next word to write or to fetch
    logic [BEAT_W-1:0]    beat_cnt;   // beats moved so far
    logic [BEAT_W-1:0]    beat_total; // burst_size + 1
    logic [BE_W-1:0]      be_q;
    logic                 err_q, end_q;
    logic                 busy_q;

    logic hit, aligned, is_read, is_write, full;
    logic wr_accept, overrun, rd_issue;
    logic sram_we;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [WORD_W-1:0]    rdata;

    assign hit      = address_data_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
    assign aligned  = address_data_in[1:0] == 2'b00;
    assign is_read  = read_n_write_in == RD;
    assign is_write = read_n_write_in == WR;
    assign full     = beat_cnt == beat_total;

    assign wr_accept = (state == WRITE) && data_valid_in && !busy_q && !full;
    assign overrun   = (state == WRITE) && data_valid_in && !busy_q && full;
    // An abort in the same cycle swallows the beat that was about to go out.
    assign rd_issue  = (state == READ) && !busy_q && !full && !end_transaction_in;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (begin_transaction_in && hit && aligned) begin
                    if (is_write)     state_next = WRITE;
                    else if (is_read) state_next = RD_WAIT;
                end
            end
            WRITE: begin
                if (end_transaction_in) state_next = IDLE;
                else if (overrun)       state_next = ABORT;
            end
            RD_WAIT: state_next = end_transaction_in ? IDLE : READ;
            // full in READ is the cycle after the last beat: the closing pulse.
            READ:    if (end_transaction_in || full) state_next = IDLE;
            ABORT:   if (end_transaction_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs and SRAM port
    always_comb begin
        data_valid_out      = rd_issue;
        address_data_out    = rd_issue ? rdata : '0;
        end_transaction_out = end_q || ((state == READ) && full);
        error_out           = err_q;
        sram_we             = wr_accept;
        sram_addr           = ptr;
        // On a stall the held word is re-fetched so rdata stays put.
        if ((state == READ) && busy_q) sram_addr = ptr - ADDR_BITS'(1);
    end

    assign busy_out = busy_q;

    // pointer, beat counter, latched request, error pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            beat_cnt   <= '0;
            beat_total <= '0;
            be_q       <= '0;
            err_q      <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            end_q <= 1'b0;
            if (state == IDLE && begin_transaction_in && hit) begin
                ptr        <= address_data_in[ADDR_BITS+1:2];
                beat_cnt   <= '0;
                beat_total <= BEAT_W'(burst_size_in) + BEAT_W'(1);
                be_q       <= byte_enables_in;
                if (!aligned) begin
                    err_q <= 1'b1;
                    end_q <= 1'b1;
                end
            end
            if (overrun) err_q <= 1'b1;
            // RD_WAIT fetches the first word, so the pointer runs one ahead.
            if (wr_accept || rd_issue || state == RD_WAIT) ptr <= ptr + ADDR_BITS'(1);
            if (wr_accept || rd_issue) beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

`ifdef BUSY_INJECT_EN
    logic [BEAT_W-1:0] busy_cnt;

    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            busy_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            if (wr_accept || rd_issue) begin
                if (busy_cnt == BEAT_W'(BUSY_PERIOD - 1)) begin
                    busy_cnt <= '0;
                    busy_q   <= state_next != IDLE;
                end else begin
                    busy_cnt <= busy_cnt + BEAT_W'(1);
                end
            end
        end
    end
`else
    assign busy_q = 1'b0;
`endif

    dma_slave_sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
        .clk   (clock),
        .we    (sram_we),
        .be    (be_q),
        .addr  (sram_addr),
        .wdata (address_data_in),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dma_bus_slave_mem.sv
module tb_dma_bus_slave_mem;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          DEPTH = 1024;
    localparam int K_SERVE = 0, K_ERR = 1, K_MISS = 2;

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        int          kind;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_transaction_in = 1'b0;
    logic        end_transaction_in = 1'b0;
    logic        read_n_write_in = 1'b0;
    logic [7:0]  burst_size_in = '0;
    logic [3:0]  byte_enables_in = '0;
    logic        data_valid_in = 1'b0;
    logic [31:0] address_data_in = '0;
    logic [31:0] address_data_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic        busy_out;
    logic        error_out;

    dma_bus_slave_mem #(.BASE_ADDR(BASE), .ADDR_BITS(10), .BUSY_PERIOD(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .begin_transaction_in (begin_transaction_in),
        .end_transaction_in   (end_transaction_in),
        .read_n_write_in      (read_n_write_in),
        .burst_size_in        (burst_size_in),
        .byte_enables_in      (byte_enables_in),
        .data_valid_in        (data_valid_in),
        .address_data_in      (address_data_in),
        .address_data_out     (address_data_out),
        .data_valid_out       (data_valid_out),
        .end_transaction_out  (end_transaction_out),
        .busy_out             (busy_out),
        .error_out            (error_out)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state
    int n_cmp = 0, n_bad = 0;
    logic [31:0] model_mem [0:DEPTH-1];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] wq[$];
    int n_end = 0, n_err = 0, n_busy = 0, bad_idle = 0;
    int first_v_cyc = 0, last_v_cyc = 0, end_cyc = 0, err_cyc = 0, bcyc = 0;
    vec_t vecs[10];

    // bus monitor, samples mid-cycle
    always @(negedge clock) begin
        if (data_valid_out === 1'b1) begin
            if (got_q.size() == 0) first_v_cyc = cyc;
            last_v_cyc = cyc;
            got_q.push_back(address_data_out);
        end else if (data_valid_out === 1'b0 && address_data_out !== 32'h0 && !reset) begin
            bad_idle++;
        end
        if (end_transaction_out === 1'b1) begin n_end++; end_cyc = cyc; end
        if (error_out === 1'b1) begin n_err++; err_cyc = cyc; end
        if (busy_out === 1'b1) n_busy++;
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_write(input int w, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[w % DEPTH][8*b +: 8] = d[8*b +: 8];
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_begin(input logic [31:0] a, input logic rnw, input logic [7:0] sz,
                               input logic [3:0] be);
        begin_transaction_in = 1'b1;
        read_n_write_in      = rnw;
        burst_size_in        = sz;
        byte_enables_in      = be;
        address_data_in      = a;
        @(negedge clock);
        bcyc = cyc;
        tick();
        begin_transaction_in = 1'b0;
        address_data_in      = '0;
    endtask

    task automatic drive_beats(input int n, input logic end_last);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            address_data_in = wq[i];
            data_valid_in   = 1'b1;
            while (busy_out && guard < 8) begin
                tick();
                guard++;
            end
            if (guard >= 8) check_int("busy_release", guard, 0);
            end_transaction_in = end_last && (i == n - 1);
            tick();
        end
        data_valid_in      = 1'b0;
        end_transaction_in = 1'b0;
        address_data_in    = '0;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [7:0] sz, input logic [3:0] be,
                               input int n);
        int w  = int'(a[11:2]);
        int e0 = n_err;
        drive_begin(a, 1'b0, sz, be);
        drive_beats(n, 1'b1);
        for (int i = 0; i < n && i <= int'(sz); i++) model_write(w + i, be, wq[i]);
        tick();
        tick();
        check_int("wr_no_err", n_err - e0, 0);
    endtask

    task automatic read_check(input logic [31:0] a, input logic [7:0] sz, input int abort_at);
        int w      = int'(a[11:2]);
        int nexp   = (abort_at >= 0) ? abort_at : int'(sz) + 1;
        int budget = int'(sz) + 1 + (int'(sz) + 1) / 4 + 8;
        int e0     = n_end;
        int r0     = n_err;
        bit aborted = 1'b0;
        exp_q.delete();
        for (int i = 0; i < nexp; i++) exp_q.push_back(model_mem[(w + i) % DEPTH]);
        got_q.delete();
        drive_begin(a, 1'b1, sz, 4'hF);
        for (int c = 0; c < budget; c++) begin
            if (abort_at >= 0 && !aborted && got_q.size() == abort_at) begin
                end_transaction_in = 1'b1;
                aborted = 1'b1;
            end else begin
                end_transaction_in = 1'b0;
            end
            tick();
        end
        end_transaction_in = 1'b0;
        check_int("rd_beats", got_q.size(), nexp);
        for (int i = 0; i < nexp && i < got_q.size(); i++) check32("rd_data", got_q[i], exp_q.pop_front());
        if (nexp > 0) check_int("rd_first_latency", first_v_cyc - bcyc, 2);
        if (abort_at < 0) begin
            check_int("rd_end_pulses", n_end - e0, 1);
            check_int("rd_end_after_last", end_cyc - last_v_cyc, 1);
        end else begin
            check_int("abort_no_end", n_end - e0, 0);
        end
        check_int("rd_no_err", n_err - r0, 0);
    endtask

    task automatic begin_only(input logic [31:0] a, input logic rnw, input int kind);
        int e0 = n_err;
        int n0 = n_end;
        got_q.delete();
        drive_begin(a, rnw, 8'd0, 4'hF);
        repeat (4) tick();
        check_int("dec_err_pulses", n_err - e0, (kind == K_ERR) ? 1 : 0);
        check_int("dec_end_pulses", n_end - n0, (kind == K_ERR) ? 1 : 0);
        check_int("dec_no_beats", got_q.size(), 0);
        if (kind == K_ERR) begin
            check_int("dec_err_cycle", err_cyc - bcyc, 1);
            check_int("dec_end_cycle", end_cyc - bcyc, 1);
        end
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        int b0;

        vecs[0] = '{32'h5000_0000, 1'b0, K_SERVE};
        vecs[1] = '{32'h5000_0FFC, 1'b0, K_SERVE};
        vecs[2] = '{32'h5000_0FFC, 1'b1, K_SERVE};
        vecs[3] = '{32'h5000_0000, 1'b1, K_SERVE};
        vecs[4] = '{32'h5000_0002, 1'b1, K_ERR};
        vecs[5] = '{32'h5000_0FFF, 1'b0, K_ERR};
        vecs[6] = '{32'h5000_0201, 1'b0, K_ERR};
        vecs[7] = '{32'h6000_0000, 1'b1, K_MISS};
        vecs[8] = '{32'h5000_1000, 1'b0, K_MISS};
        vecs[9] = '{32'h4FFF_FFFC, 1'b1, K_MISS};

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check32("rst_data", address_data_out, 32'h0);
        check32("rst_valid", {31'b0, data_valid_out}, 32'h0);
        check32("rst_end", {31'b0, end_transaction_out}, 32'h0);
        check32("rst_busy", {31'b0, busy_out}, 32'h0);
        check32("rst_err", {31'b0, error_out}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // preload the whole window with 256-beat bursts
        for (int k = 0; k < 4; k++) begin
            wq.delete();
            for (int i = 0; i < 256; i++) wq.push_back($urandom());
            write_burst(BASE + 32'(k * 1024), 8'd255, 4'hF, 256);
        end
        read_check(BASE + 32'h400, 8'd255, -1);

        // single write then read back
        wq = '{32'hDEADBEEF};
        write_burst(BASE + 32'h10, 8'd0, 4'hF, 1);
        read_check(BASE + 32'h10, 8'd0, -1);
        check32("single_word", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hDEADBEEF);

        // burst read of 1..4
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        write_burst(BASE + 32'h10, 8'd3, 4'hF, 4);
        read_check(BASE + 32'h10, 8'd3, -1);

        // wrap and byte enables
        wq = '{32'hAAAA_1111, 32'hBBBB_2222};
        write_burst(BASE + 32'hFFC, 8'd1, 4'b0011, 2);
        read_check(BASE + 32'hFFC, 8'd1, -1);
        t = got_q.size() > 1 ? got_q[0] : 32'hx;
        check32("wrap_low_1023", {16'h0, t[15:0]}, 32'h1111);
        t = got_q.size() > 1 ? got_q[1] : 32'hx;
        check32("wrap_low_0", {16'h0, t[15:0]}, 32'h2222);

        // table of decode cases
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].kind == K_SERVE) begin
                if (vecs[v].rnw == 1'b0) begin
                    wq = '{$urandom()};
                    write_burst(vecs[v].addr, 8'd0, 4'hF, 1);
                end
                read_check(vecs[v].addr, 8'd0, -1);
            end else begin
                begin_only(vecs[v].addr, vecs[v].rnw, vecs[v].kind);
            end
        end

        // write overrun, then a begin while stuck in the abort state
        b0 = n_err;
        wq = '{32'h1111_1111, 32'h2222_2222};
        drive_begin(BASE + 32'h20, 1'b0, 8'd0, 4'hF);
        drive_beats(2, 1'b0);
        model_write(8, 4'hF, 32'h1111_1111);
        tick();
        check_int("overrun_err", n_err - b0, 1);
        got_q.delete();
        drive_begin(BASE + 32'h20, 1'b1, 8'd0, 4'hF);
        repeat (3) tick();
        check_int("begin_ignored_in_abort", got_q.size(), 0);
        end_transaction_in = 1'b1;
        tick();
        end_transaction_in = 1'b0;
        tick();
        read_check(BASE + 32'h20, 8'd1, -1);

        // read abort after three beats
        read_check(BASE + 32'h40, 8'd7, 3);

        // reset in the middle of a write burst
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back($urandom());
        drive_begin(BASE + 32'h190, 1'b0, 8'd7, 4'hF);
        drive_beats(3, 1'b0);
        for (int i = 0; i < 3; i++) model_write(100 + i, 4'hF, wq[i]);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check32("midrst_data", address_data_out, 32'h0);
        check32("midrst_flags", {27'b0, data_valid_out, end_transaction_out, busy_out, error_out, 1'b0}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        read_check(BASE + 32'h190, 8'd2, -1);
        read_check(BASE + 32'h10, 8'd3, -1);

`ifdef BUSY_INJECT_EN
        b0 = n_busy;
        read_check(BASE + 32'h40, 8'd7, -1);
        check_int("busy_cycles", n_busy - b0, 2);
`endif

        // random traffic against the model
        for (int r = 0; r < 24; r++) begin
            int          w   = $urandom_range(0, DEPTH - 1);
            logic [7:0]  sz  = 8'($urandom_range(0, 19));
            logic [3:0]  be  = 4'($urandom_range(1, 15));
            logic [31:0] a   = BASE + 32'(w * 4);
            if ($urandom_range(0, 1) == 1) begin
                read_check(a, sz, -1);
            end else begin
                wq.delete();
                for (int i = 0; i <= int'(sz); i++) wq.push_back($urandom());
                write_burst(a, sz, be, int'(sz) + 1);
            end
        end
        read_check(BASE + 32'hFC0, 8'd31, -1);

`ifndef BUSY_INJECT_EN
        check_int("busy_never", n_busy, 0);
`endif
        check_int("idle_data_zero", bad_idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
